// File: rtl/ethernet_pkg.sv
// Shared MDIO definitions: FSM state encoding and Clause 22 opcodes,
// used by both the PHY-side responder and the SoC MDIO master.
package ethernet_pkg;

    typedef enum logic [2:0] {
        IDLE,
        START,
        OPCODE,
        PHY_ADDRESS,
        REG_ADDRESS,
        TURN_AROUND,
        DATA
    } mdio_state_t;

    localparam logic [1:0] MDIO_READ  = 2'b10;
    localparam logic [1:0] MDIO_WRITE = 2'b01;

endpackage

// File: rtl/mdio_synchronizer.sv
// Brings MDC/MDIO into the clk_i domain and flags each MDC rising edge
// with a one-cycle sample pulse aligned to the matching MDIO bit.
module mdio_synchronizer (
    input  logic clk_i,
    input  logic rst_i,
    input  logic mdc_i,
    input  logic mdio_i,
    output logic sample_o,
    output logic mdio_sync_o
);

    logic [1:0] mdc_ff;
    logic [1:0] mdio_ff;
    logic       mdc_prev;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            mdc_ff      <= '0;
            mdio_ff     <= '0;
            mdc_prev    <= 1'b0;
            sample_o    <= 1'b0;
            mdio_sync_o <= 1'b0;
        end else begin
            // NOTE: non-blocking, so every stage captures the previous stage's old value.
            mdc_ff      <= {mdc_ff[0], mdc_i};
            mdio_ff     <= {mdio_ff[0], mdio_i};
            mdc_prev    <= mdc_ff[1];
            sample_o    <= mdc_ff[1] & ~mdc_prev;
            mdio_sync_o <= mdio_ff[1];
        end
    end

endmodule

// File: rtl/ethernet_phy_mdio.sv
// Clause 22 MDIO responder: decodes frames for PHY_ADDRESS into local
// register-port strobes and returns read data on MDIO.
module ethernet_phy_mdio
    import ethernet_pkg::*;
#(
    parameter logic [4:0]  PHY_ADDRESS   = 5'b00001,
    parameter int unsigned PREAMBLE_BITS = 32
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        mdc_i,
    input  logic        mdio_i,
    output logic        mdio_o,
    output logic        mdio_oe_o,
    output logic [4:0]  reg_address_o,
    output logic        reg_read_o,
    input  logic [15:0] reg_rdata_i,
    output logic        reg_write_o,
    output logic [15:0] reg_wdata_o,
    output logic        done_o,
    output logic        error_o
);

    localparam logic [5:0] PRE_MAX = 6'(PREAMBLE_BITS);

    logic        sample;
    logic        mdio_s;
    mdio_state_t state;
    logic [4:0]  bit_cnt;
    logic [5:0]  pre_cnt;
    logic        op_msb;
    logic        is_read;
    logic        match;
    logic [3:0]  phy_shift;
    logic [15:0] shift_reg;
    logic        load_rdata;
    logic [1:0]  op_bits;

    assign op_bits = {op_msb, mdio_s};

    mdio_synchronizer u_sync (
        .clk_i       (clk_i),
        .rst_i       (rst_i),
        .mdc_i       (mdc_i),
        .mdio_i      (mdio_i),
        .sample_o    (sample),
        .mdio_sync_o (mdio_s)
    );

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state         <= IDLE;
            bit_cnt       <= '0;
            pre_cnt       <= '0;
            op_msb        <= 1'b0;
            is_read       <= 1'b0;
            match         <= 1'b0;
            phy_shift     <= '0;
            shift_reg     <= '0;
            load_rdata    <= 1'b0;
            mdio_o        <= 1'b0;
            mdio_oe_o     <= 1'b0;
            reg_address_o <= '0;
            reg_read_o    <= 1'b0;
            reg_write_o   <= 1'b0;
            reg_wdata_o   <= '0;
            done_o        <= 1'b0;
            error_o       <= 1'b0;
        end else begin
            reg_read_o  <= 1'b0;
            reg_write_o <= 1'b0;
            done_o      <= 1'b0;
            error_o     <= 1'b0;

            // Read data is valid the cycle after the strobe; samples are >= 8 cycles apart.
            load_rdata <= reg_read_o;
            if (load_rdata) begin
                shift_reg <= reg_rdata_i;
            end

            if (sample) begin
                bit_cnt <= bit_cnt + 5'd1;
                case (state)
                    IDLE: begin
                        bit_cnt <= '0;
                        if (mdio_s) begin
                            if (pre_cnt != PRE_MAX) begin
                                pre_cnt <= pre_cnt + 6'd1;
                            end
                        end else if (pre_cnt == PRE_MAX) begin
                            state   <= START;
                            pre_cnt <= '0;
                        end else begin
                            pre_cnt <= '0;
                        end
                    end

                    START: begin
                        bit_cnt <= '0;
                        if (mdio_s) begin
                            state <= OPCODE;
                        end else begin
                            error_o <= 1'b1;
                            state   <= IDLE;
                        end
                    end

                    OPCODE: begin
                        if (bit_cnt == 5'd0) begin
                            op_msb <= mdio_s;
                        end else begin
                            bit_cnt <= '0;
                            if (op_bits == MDIO_READ || op_bits == MDIO_WRITE) begin
                                is_read <= (op_bits == MDIO_READ);
                                state   <= ethernet_pkg::PHY_ADDRESS;
                            end else begin
                                error_o <= 1'b1;
                                state   <= IDLE;
                            end
                        end
                    end

                    ethernet_pkg::PHY_ADDRESS: begin
                        phy_shift <= {phy_shift[2:0], mdio_s};
                        if (bit_cnt == 5'd4) begin
                            match   <= ({phy_shift, mdio_s} == PHY_ADDRESS);
                            bit_cnt <= '0;
                            state   <= REG_ADDRESS;
                        end
                    end

                    REG_ADDRESS: begin
                        reg_address_o <= {reg_address_o[3:0], mdio_s};
                        if (bit_cnt == 5'd4) begin
                            reg_read_o <= match & is_read;
                            bit_cnt    <= '0;
                            state      <= TURN_AROUND;
                        end
                    end

                    TURN_AROUND: begin
                        if (bit_cnt == 5'd0) begin
                            if (match && is_read) begin
                                mdio_oe_o <= 1'b1;
                                mdio_o    <= 1'b0;
                            end
                        end else begin
                            bit_cnt <= '0;
                            state   <= DATA;
                            // The sample ending TA launches bit 15 so the master sees it on the next MDC rise.
                            if (match && is_read) begin
                                mdio_o    <= shift_reg[15];
                                shift_reg <= {shift_reg[14:0], 1'b0};
                            end
                        end
                    end

                    DATA: begin
                        if (is_read) begin
                            if (bit_cnt == 5'd15) begin
                                mdio_oe_o <= 1'b0;
                                mdio_o    <= 1'b0;
                            end else if (match) begin
                                mdio_o    <= shift_reg[15];
                                shift_reg <= {shift_reg[14:0], 1'b0};
                            end
                        end else begin
                            shift_reg <= {shift_reg[14:0], mdio_s};
                            if (bit_cnt == 5'd15 && match) begin
                                reg_wdata_o <= {shift_reg[14:0], mdio_s};
                                reg_write_o <= 1'b1;
                            end
                        end
                        if (bit_cnt == 5'd15) begin
                            done_o  <= match;
                            bit_cnt <= '0;
                            state   <= IDLE;
                        end
                    end

                    default: begin
                        bit_cnt <= '0;
                        state   <= IDLE;
                    end
                endcase
            end
        end
    end

endmodule
